// File: rtl/lcd_scanout_pkg.sv
// Shared types and constants for the LCD frame-buffer scanout engine.
// Frame geometry helpers and the colour layout of a stored pixel.
package lcd_scanout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DONE,
    DRAIN,
    FLUSH
  } state_t;

  localparam int COLOR_W   = 8;
  localparam int RED_LSB   = 16;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 0;

  function automatic int words(
    input int h,
    input int v,
    input int pw,
    input int dw
  );
    return h * v * pw / dw;
  endfunction

  function automatic int pixels_per_word(
    input int pw,
    input int dw
  );
    return dw / pw;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Single-clock show-ahead FIFO holding prefetched frame-buffer words.
// The head word is visible on rdata whenever the FIFO is not empty.
module scanout_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_scanout.sv
// Frame-buffer scanout: burst-prefetches a frame from SDRAM into a FIFO
// and pops registered RGB pixels on LCD ticks during active video.
module lcd_scanout
  import lcd_scanout_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int DATA_WIDTH  = 64,
  parameter int PIXEL_WIDTH = 32,
  parameter int ADDR_WIDTH  = 29,
  parameter int BURST       = 8,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  input  logic                  next_frame,
  input  logic                  tick,
  input  logic                  data_enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            burstcount,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [DATA_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  underflow
);

  localparam int WORDS_N = words(H_ACTIVE, V_ACTIVE, PIXEL_WIDTH, DATA_WIDTH);
  localparam int PPW     = pixels_per_word(PIXEL_WIDTH, DATA_WIDTH);
  localparam int SEL_W   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int REQ_W   = $clog2(WORDS_N + 1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   base;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        occupancy;
  logic [CNT_W:0]          used;
  logic [REQ_W-1:0]        requested;
  logic [SEL_W-1:0]        pixel_sel;
  logic [DATA_WIDTH-1:0]   head;
  logic                    pend;
  logic                    latch;
  logic                    credit_ok;
  logic                    accept;
  logic                    keep;
  logic                    pop_req;
  logic                    pop_ok;
  logic                    wrap;
  logic                    fifo_empty;
  logic                    fifo_full;
  int                      off;

  // Credit counts words already in the FIFO plus words still in flight.
  assign used       = {1'b0, occupancy} + {1'b0, outstanding};
  assign credit_ok  = (used <= (CNT_W+1)'(FIFO_DEPTH - BURST));
  assign read       = (state == FETCH) && credit_ok;
  assign burstcount = read ? 8'(BURST) : 8'd0;
  assign accept     = read && !waitrequest;
  assign keep       = readdatavalid && (state == FETCH || state == DONE);
  assign pop_req    = tick && data_enable && !next_frame && (state != FLUSH);
  assign pop_ok     = pop_req && !fifo_empty;
  assign wrap       = (pixel_sel == SEL_W'(PPW - 1));
  assign off        = int'(pixel_sel) * PIXEL_WIDTH;

  scanout_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (keep && !fifo_full),
    .pop     (pop_ok && wrap),
    .flush   (state == FLUSH),
    .wdata   (readdata),
    .rdata   (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (occupancy)
  );

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        if (next_frame) begin
          latch      = 1'b1;
          state_next = FLUSH;
        end
      end
      FETCH: begin
        latch = next_frame;
        // A request stalled by waitrequest must finish before draining.
        if (next_frame || pend) begin
          if (!(read && waitrequest)) begin
            state_next = DRAIN;
          end
        end else if (accept &&
                     requested == REQ_W'(WORDS_N - BURST)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (next_frame) begin
          latch      = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base        <= '0;
      address     <= '0;
      outstanding <= '0;
      requested   <= '0;
      pend        <= 1'b0;
    end else begin
      state <= state_next;
      pend  <= (state == FETCH) && (pend || next_frame) &&
               read && waitrequest;
      if (latch) begin
        base <= frame_base;
      end
      if (state == FLUSH) begin
        address   <= base;
        requested <= '0;
      end else if (accept) begin
        address   <= address + ADDR_WIDTH'(BURST);
        requested <= requested + REQ_W'(BURST);
      end
      outstanding <= outstanding
                   + (accept ? CNT_W'(BURST) : CNT_W'(0))
                   - (readdatavalid ? CNT_W'(1) : CNT_W'(0));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_sel <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      underflow <= 1'b0;
    end else begin
      if (state == FLUSH) begin
        pixel_sel <= '0;
      end else if (pop_ok) begin
        pixel_sel <= wrap ? '0 : pixel_sel + SEL_W'(1);
      end
      if (pop_req && fifo_empty) begin
        red       <= '0;
        green     <= '0;
        blue      <= '0;
        underflow <= 1'b1;
      end else if (pop_ok) begin
        red   <= head[off + RED_LSB   +: COLOR_W];
        green <= head[off + GREEN_LSB +: COLOR_W];
        blue  <= head[off + BLUE_LSB  +: COLOR_W];
      end else if (tick && !data_enable) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Randomised bench for lcd_scanout: Avalon memory model plus a
// frame-level pixel stream reference.
module tb_lcd_scanout;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int DW    = 64;
  localparam int PW    = 32;
  localparam int AW    = 29;
  localparam int BL    = 8;
  localparam int FD    = 16;
  localparam int WORDS = H * V * PW / DW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          next_frame = 1'b0;
  logic          tick = 1'b0;
  logic          data_enable = 1'b0;
  logic [AW-1:0] address;
  logic [7:0]    burstcount;
  logic          read;
  logic          waitrequest = 1'b0;
  logic [DW-1:0] readdata = '0;
  logic          readdatavalid = 1'b0;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          underflow;

  always #5 clock = ~clock;

  lcd_scanout #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .DATA_WIDTH  (DW),
    .PIXEL_WIDTH (PW),
    .ADDR_WIDTH  (AW),
    .BURST       (BL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .frame_base    (frame_base),
    .next_frame    (next_frame),
    .tick          (tick),
    .data_enable   (data_enable),
    .address       (address),
    .burstcount    (burstcount),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .underflow     (underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] beat_addr_q[$];
  int            beat_ep_q[$];
  int            epoch = 0;
  logic [AW-1:0] fbase = '0;
  logic [AW-1:0] next_addr = '0;
  logic [AW-1:0] stale_addr = '0;
  logic [AW-1:0] hold_addr = '0;
  bit            stale_ok = 0;
  bit            started = 0;
  bit            hold = 0;
  int            acc_words = 0;
  int            delivered = 0;
  int            npix = 0;
  logic [7:0]    er = '0;
  logic [7:0]    eg = '0;
  logic [7:0]    eb = '0;
  logic          euf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    logic [63:0]   w;
    m = a * AW'(7) + AW'(5);
    w = {8'hA5, m[23:0], 8'h3C, a[23:0] ^ 24'h5A5A5A};
    if (a == AW'(32'h1000)) w = 64'h00AABBCC_00112233;
    return w;
  endfunction

  task automatic step(input bit nf, input bit de, input logic [AW-1:0] nb,
                      input int wpct, input int vpct);
    logic [63:0] w;
    logic [31:0] p;
    int          occ_pre;
    @(negedge clock);
    check("red", red, er);
    check("green", green, eg);
    check("blue", blue, eb);
    check("underflow", underflow, euf);
    check("burstcount", burstcount, read ? 64'(BL) : 64'd0);
    if (hold) begin
      check("hold_read", read, 1);
      check("hold_addr", address, hold_addr);
    end
    if (!started) check("idle_read", read, 0);
    else if (!stale_ok && acc_words >= WORDS) check("done_read", read, 0);

    tick        = ~tick;
    next_frame  = nf;
    frame_base  = nb;
    data_enable = de;
    waitrequest = ($urandom_range(0, 99) < wpct);
    if (beat_addr_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
      readdatavalid = 1'b1;
      readdata      = mem_word(beat_addr_q[0]);
    end else begin
      readdatavalid = 1'b0;
      readdata      = {$urandom, $urandom};
    end

    occ_pre = delivered - npix / 2;
    if (read && !waitrequest) begin
      if (stale_ok) begin
        check("stale_addr", address, stale_addr);
        stale_ok = 0;
        for (int i = 0; i < BL; i++) begin
          beat_addr_q.push_back(address + AW'(i));
          beat_ep_q.push_back(epoch - 1);
        end
      end else begin
        check("req_addr", address, next_addr);
        check("req_in_frame", acc_words < WORDS, 1);
        for (int i = 0; i < BL; i++) begin
          beat_addr_q.push_back(address + AW'(i));
          beat_ep_q.push_back(epoch);
        end
        acc_words += BL;
        next_addr += AW'(BL);
        check("credit", (acc_words - npix / 2) <= FD, 1);
      end
    end
    hold      = read && waitrequest;
    hold_addr = address;

    if (tick) begin
      if (!de) begin
        er = '0; eg = '0; eb = '0;
      end else if (!nf) begin
        if (npix / 2 < delivered) begin
          w  = mem_word(fbase + AW'(npix / 2));
          p  = (npix % 2 == 1) ? w[63:32] : w[31:0];
          er = p[23:16];
          eg = p[15:8];
          eb = p[7:0];
          npix++;
        end else begin
          er = '0; eg = '0; eb = '0;
          euf = 1'b1;
        end
      end
    end

    if (readdatavalid) begin
      if (beat_ep_q[0] == epoch) begin
        check("push_room", occ_pre < FD, 1);
        delivered++;
      end
      void'(beat_addr_q.pop_front());
      void'(beat_ep_q.pop_front());
    end

    if (nf) begin
      if (hold) begin
        stale_ok   = 1;
        stale_addr = next_addr;
      end
      epoch++;
      fbase     = nb;
      next_addr = nb;
      acc_words = 0;
      delivered = 0;
      npix      = 0;
      started   = 1;
    end
  endtask

  // Vertical blanking uses a healthy memory; active video uses the given one.
  task automatic frame(input logic [AW-1:0] nb, input int act,
                       input int wpct, input int vpct);
    step(1, 0, nb, 30, 75);
    repeat (79) step(0, 0, nb, 30, 75);
    repeat (act) step(0, $urandom_range(0, 99) < 85, nb, wpct, vpct);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_read", read, 0);
    check("rst_address", address, 0);
    check("rst_burstcount", burstcount, 0);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_underflow", underflow, 0);
    reset_n = 1'b1;
    repeat (4) step(0, 0, '0, 30, 75);
    frame(AW'(32'h1000), 128, 30, 75);
    frame(AW'(32'h8000), 40, 30, 75);
    frame(AW'(32'h2468), 128, 0, 100);
    for (int f = 0; f < 3; f++) begin
      frame(AW'($urandom), $urandom_range(40, 128), 30, 75);
    end
    frame(AW'(32'h4000), 128, 100, 0);
    for (int f = 0; f < 3; f++) begin
      frame(AW'($urandom), $urandom_range(40, 128), 20, 80);
    end
    step(0, 0, '0, 30, 75);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Frame-buffer scanout engine between the HPS F2H SDRAM port and the LCD pixel pins.
- Prefetches a frame from SDRAM with Avalon-MM burst reads into an on-chip FIFO. Pops pixels on LCD ticks during active video and presents registered RGB to the GPIO mapping.
- Parametrised successor to the fixed-text LCD path: width, depth, burst length and resolution are generic.
- Adds double-buffered frame base latching and underflow detection.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- DATA_WIDTH, 64, Avalon readdata width (bits)
- PIXEL_WIDTH, 32, bits per stored pixel {8'x, R, G, B}; must divide DATA_WIDTH
- ADDR_WIDTH, 29, Avalon word-address width
- BURST, 8, words per read burst; must be a power of 2 dividing the frame word count
- FIFO_DEPTH, 64, FIFO words; power of 2, at least 2*BURST

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- frame_base  in  ADDR_WIDTH  word address of the next frame; sampled only at next_frame
- next_frame  in  1  one-clock pulse at the start of vertical blanking
- tick  in  1  pixel-clock enable (one clock in two)
- data_enable  in  1  active-video qualifier from the timing generator
- address  out  ADDR_WIDTH  Avalon read address
- burstcount  out  8  constant BURST while read is high
- read  out  1  Avalon read request
- waitrequest  in  1  Avalon stall
- readdata  in  DATA_WIDTH  Avalon read data
- readdatavalid  in  1  Avalon data strobe
- red, green, blue  out  8 each  registered pixel colour
- underflow  out  1  sticky flag: a pop found the FIFO empty

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; base, address, outstanding, occupancy and pixel_sel all 0.
- Derived constant: WORDS = H_ACTIVE*V_ACTIVE*PIXEL_WIDTH/DATA_WIDTH (800x480 with 32-bit pixels in 64-bit words gives 192000).
- State machine:
  - IDLE: wait for the first next_frame, then go to FLUSH.
  - FETCH: assert read with the current address when credit >= BURST, where credit = FIFO_DEPTH - occupancy - outstanding.
    - read, address and burstcount are held stable while waitrequest is high.
    - On acceptance (read & !waitrequest): address += BURST, outstanding += BURST, requested += BURST.
    - When requested == WORDS, go to DONE.
  - DONE: read low; wait for next_frame.
  - DRAIN: read low; discard readdatavalid beats, decrementing outstanding; when outstanding == 0, go to FLUSH.
  - FLUSH (one cycle): empty the FIFO, pixel_sel = 0, address = latched base, requested = 0, then go to FETCH.
- next_frame handling:
  - In FETCH or DONE, next_frame latches frame_base into base and moves to DRAIN.
  - In FETCH, a request already held under waitrequest completes first, then the FSM goes to DRAIN; its beats are discarded.
- Data beats:
  - In FETCH and DONE, each readdatavalid pushes readdata into the FIFO and decrements outstanding.
  - Push into a full FIFO is impossible under the credit rule; the bench asserts this never happens.
- Pixel pop (tick & data_enable & state != FLUSH):
  - Pixel pixel_sel is taken from bits [pixel_sel*PIXEL_WIDTH +: PIXEL_WIDTH] of the FIFO head; lowest pixel first.
  - pixel_sel increments and wraps at DATA_WIDTH/PIXEL_WIDTH; the FIFO word is popped on wrap.
  - red/green/blue = bits [23:16]/[15:8]/[7:0] of the pixel, registered on the same edge: one clock of latency.
- Underflow:
  - Pop while the FIFO is empty: output 0, pixel_sel unchanged, underflow set.
  - underflow is sticky until reset.
- Blanking: when tick & !data_enable, colours are driven to 0.
- Simultaneous events:
  - next_frame has priority over a pop in the same cycle; the pop is ignored.
  - A push and a pop in the same cycle leave occupancy unchanged.
- Reset mid-burst: everything clears asynchronously. The team requires that the interconnect also be reset, so no outstanding beats are tracked across reset.

Decomposition:
- Package lcd_scanout_pkg holds:
  - state enum {IDLE, FETCH, DONE, DRAIN, FLUSH}
  - WORDS and PIXELS_PER_WORD localparam functions
  - the colour bit-field constants
- Sub-module scanout_fifo:
  - synchronous single-clock FIFO, parameters WIDTH/DEPTH
  - ports: push, pop, flush, empty, full, count
  - show-ahead read data

Test Plan:
1. Reset, next_frame with frame_base=0x1000, zero-wait memory returning data = address -> first read at 0x1000 with burstcount 8; consecutive bursts at 0x1008, 0x1010; outstanding never exceeds 64.
2. Word 0x00AABBCC_00112233 at head, two ticks with data_enable -> red/green/blue = 11/22/33, then AA/BB/CC; FIFO pops once.
3. waitrequest held for 5 clocks -> address/read/burstcount stable throughout; exactly one burst accepted.
4. next_frame mid-fetch with 16 beats outstanding, new base 0x8000 -> 16 beats discarded, FIFO empty, next read at 0x8000.
5. Memory stalled, data_enable high -> colours 0, underflow=1 and stays 1 after data resumes.
6. Full frame at H=8, V=2 -> exactly 8 words requested (a single burst), then DONE with read low until next_frame.
